// File: rtl/exc_collector.sv
// Exception collector: tracks per-slot exception flags and drives CP0.
// Optional exception counter enabled by defining EXC_STATS_EN.
module exc_collector #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        if_bd,
    input  logic        if_adel,
    input  logic        id_ri,
    input  logic        id_sys,
    input  logic        id_brk,
    input  logic        id_eret,
    input  logic        ex_ov,
    input  logic        mem_adel,
    input  logic        mem_ades,
    input  logic [31:0] mem_vaddr,
    input  logic        cp0_handle,
    input  logic [31:0] cp0_epc,
    output logic [6:0]  exc_vec,
    output logic        exc_bd,
    output logic [31:0] epc_out,
    output logic [31:0] badvaddr_out,
    output logic        eret_out,
    output logic        mem_kill,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef EXC_STATS_EN
    ,
    output logic [31:0] exc_count
`endif
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [6:0]  vec;
        logic        eret;
    } slot_t;

    typedef enum logic {
        RUN,
        REDIR
    } state_t;

    state_t state;
    slot_t  id_s;
    slot_t  ex_s;
    slot_t  mem_s;
    slot_t  id_n;
    slot_t  ex_n;
    slot_t  mem_n;

    logic       commit;
    logic [4:0] hi;
    logic       take;

    function automatic logic [31:0] epc_of(input slot_t s);
        return s.bd ? s.pc - 32'd4 : s.pc;
    endfunction

    // Next-slot contents when the pipeline advances
    always_comb begin
        id_n       = '0;
        id_n.valid = if_valid;
        id_n.pc    = if_pc;
        id_n.bd    = if_bd;
        id_n.vec   = {if_adel, 6'b000000};

        ex_n        = id_s;
        ex_n.vec[5] = id_s.vec[5] | (id_ri & ~id_s.vec[6]);
        ex_n.vec[3] = id_s.vec[3] | (id_sys & ~id_s.vec[6]);
        ex_n.vec[2] = id_s.vec[2] | (id_brk & ~id_s.vec[6]);
        ex_n.eret   = id_eret & ~id_s.vec[6];

        mem_n        = ex_s;
        mem_n.vec[4] = ex_s.vec[4] | ex_ov;
    end

    // Commit-side outputs toward CP0
    always_comb begin
        commit  = mem_s.valid & ~stall & (state == RUN);
        hi      = mem_s.vec[6:2];
        exc_vec = '0;
        if (commit) begin
            exc_vec = {hi, (hi != 5'd0) ? 2'b00 : {mem_adel, mem_ades}};
        end
        mem_kill = mem_s.valid & ((exc_vec != 7'd0) | cp0_handle);
        exc_bd   = mem_s.bd;
        if (mem_s.valid) begin
            epc_out = epc_of(mem_s);
        end else if (ex_s.valid) begin
            epc_out = epc_of(ex_s);
        end else if (id_s.valid) begin
            epc_out = epc_of(id_s);
        end else begin
            epc_out = if_pc;
        end
        badvaddr_out = mem_s.vec[6] ? mem_s.pc : mem_vaddr;
        eret_out = commit & mem_s.eret & (exc_vec == 7'd0) & ~cp0_handle;
        take     = (state == RUN) & (cp0_handle | eret_out);
    end

    // Slot pipeline and RUN/REDIR redirect state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            id_s           <= '0;
            ex_s           <= '0;
            mem_s          <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (take) begin
                        state          <= REDIR;
                        id_s           <= '0;
                        ex_s           <= '0;
                        mem_s          <= '0;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= cp0_handle ? EXC_VECTOR : cp0_epc;
                    end else if (!stall) begin
                        id_s  <= id_n;
                        ex_s  <= ex_n;
                        mem_s <= mem_n;
                    end
                end
                REDIR: begin
                    state          <= RUN;
                    id_s           <= '0;
                    ex_s           <= '0;
                    mem_s          <= '0;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXC_STATS_EN
    // Count exceptions taken (eret redirects excluded)
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count <= '0;
        end else if ((state == RUN) && cp0_handle) begin
            exc_count <= exc_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exc_collector.sv
// Directed bench for exc_collector.
// Hand-computed expectations for commit, redirect and reset behaviour.
module tb_exc_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_bd;
    logic        if_adel;
    logic        id_ri;
    logic        id_sys;
    logic        id_brk;
    logic        id_eret;
    logic        ex_ov;
    logic        mem_adel;
    logic        mem_ades;
    logic [31:0] mem_vaddr;
    logic        cp0_handle;
    logic [31:0] cp0_epc;
    logic [6:0]  exc_vec;
    logic        exc_bd;
    logic [31:0] epc_out;
    logic [31:0] badvaddr_out;
    logic        eret_out;
    logic        mem_kill;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef EXC_STATS_EN
    logic [31:0] exc_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    exc_collector dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_bd(if_bd),
        .if_adel(if_adel),
        .id_ri(id_ri),
        .id_sys(id_sys),
        .id_brk(id_brk),
        .id_eret(id_eret),
        .ex_ov(ex_ov),
        .mem_adel(mem_adel),
        .mem_ades(mem_ades),
        .mem_vaddr(mem_vaddr),
        .cp0_handle(cp0_handle),
        .cp0_epc(cp0_epc),
        .exc_vec(exc_vec),
        .exc_bd(exc_bd),
        .epc_out(epc_out),
        .badvaddr_out(badvaddr_out),
        .eret_out(eret_out),
        .mem_kill(mem_kill),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
`ifdef EXC_STATS_EN
        ,
        .exc_count(exc_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall      = 1'b0;
        if_valid   = 1'b0;
        if_pc      = '0;
        if_bd      = 1'b0;
        if_adel    = 1'b0;
        id_ri      = 1'b0;
        id_sys     = 1'b0;
        id_brk     = 1'b0;
        id_eret    = 1'b0;
        ex_ov      = 1'b0;
        mem_adel   = 1'b0;
        mem_ades   = 1'b0;
        mem_vaddr  = '0;
        cp0_handle = 1'b0;
        cp0_epc    = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_flush", flush, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_vec", exc_vec, 0);
        chk("rst_eret", eret_out, 0);
        chk("rst_kill", mem_kill, 0);
        chk("rst_bd", exc_bd, 0);

        // syscall, with a load error masked by the higher flag
        if_valid = 1'b1;
        if_pc    = 32'h8000_1000;
        step();
        if_valid = 1'b0;
        id_sys   = 1'b1;
        step();
        id_sys = 1'b0;
        step();
        mem_adel = 1'b1;
        #1;
        chk("sys_vec", exc_vec, 7'b0001000);
        chk("sys_epc", epc_out, 32'h8000_1000);
        chk("sys_kill", mem_kill, 1);
        mem_adel   = 1'b0;
        cp0_handle = 1'b1;
        step();
        stall = 1'b1;
        #1;
        chk("sys_flush", flush, 1);
        chk("sys_rv", redirect_valid, 1);
        chk("sys_rpc", redirect_pc, 32'hBFC0_0380);
        chk("redir_vec", exc_vec, 0);
        step();
        cp0_handle = 1'b0;
        stall      = 1'b0;
        chk("post_flush", flush, 0);
        chk("post_rv", redirect_valid, 0);

        // store address error in a delay slot
        do_reset();
        if_valid = 1'b1;
        if_pc    = 32'h8000_2004;
        if_bd    = 1'b1;
        step();
        if_valid = 1'b0;
        if_bd    = 1'b0;
        step();
        step();
        mem_ades  = 1'b1;
        mem_vaddr = 32'h8000_0003;
        #1;
        chk("ades_vec", exc_vec, 7'b0000001);
        chk("ades_bd", exc_bd, 1);
        chk("ades_epc", epc_out, 32'h8000_2000);
        chk("ades_bva", badvaddr_out, 32'h8000_0003);
        chk("ades_kill", mem_kill, 1);
        mem_ades = 1'b0;

        // misaligned fetch also decoding RI and eret
        do_reset();
        if_valid = 1'b1;
        if_pc    = 32'h8000_0002;
        if_adel  = 1'b1;
        step();
        if_valid = 1'b0;
        if_adel  = 1'b0;
        id_ri    = 1'b1;
        id_eret  = 1'b1;
        step();
        id_ri   = 1'b0;
        id_eret = 1'b0;
        step();
        mem_vaddr = 32'h1234_5678;
        #1;
        chk("pcadel_vec", exc_vec, 7'b1000000);
        chk("pcadel_bva", badvaddr_out, 32'h8000_0002);
        chk("pcadel_eret", eret_out, 0);
        chk("pcadel_epc", epc_out, 32'h8000_0002);

        // eret with younger instructions behind it
        do_reset();
        if_valid = 1'b1;
        if_pc    = 32'h8000_4000;
        step();
        if_pc   = 32'h8000_4004;
        id_eret = 1'b1;
        step();
        id_eret = 1'b0;
        if_pc   = 32'h8000_4008;
        step();
        cp0_epc = 32'h8000_3000;
        #1;
        chk("eret_out", eret_out, 1);
        chk("eret_vec", exc_vec, 0);
        chk("eret_kill", mem_kill, 0);
        chk("eret_epc", epc_out, 32'h8000_4000);
        if_pc = 32'h8000_400c;
        step();
        chk("eret_rpc", redirect_pc, 32'h8000_3000);
        chk("eret_flush", flush, 1);
        chk("eret_rv", redirect_valid, 1);
        step();
        if_valid = 1'b0;
        if_pc    = 32'h1111_0000;
        #1;
        chk("eret_empty", epc_out, 32'h1111_0000);
        chk("eret_flush0", flush, 0);

        // overflow held in MEM by stall
        do_reset();
        if_valid = 1'b1;
        if_pc    = 32'h8000_5000;
        step();
        if_valid = 1'b0;
        step();
        ex_ov = 1'b1;
        step();
        ex_ov = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ov_stall", exc_vec, 0);
            step();
        end
        stall = 1'b0;
        #1;
        chk("ov_vec", exc_vec, 7'b0010000);
        chk("ov_epc", epc_out, 32'h8000_5000);

        // interrupt on bubble, delay-slot pc wraps
        do_reset();
        if_valid = 1'b1;
        if_pc    = 32'h0000_0000;
        if_bd    = 1'b1;
        step();
        if_valid = 1'b0;
        if_bd    = 1'b0;
        if_pc    = 32'h5555_0000;
        #1;
        chk("wrap_epc", epc_out, 32'hFFFF_FFFC);
        cp0_handle = 1'b1;
        step();
        cp0_handle = 1'b0;
        chk("irq_rpc", redirect_pc, 32'hBFC0_0380);
        chk("irq_flush", flush, 1);

        // reset while redirecting
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_flush", flush, 0);
        chk("rr_rv", redirect_valid, 0);
        chk("rr_rpc", redirect_pc, 0);
        if_pc = 32'h2222_0000;
        step();
        step();
        chk("rr_empty", epc_out, 32'h2222_0000);
        chk("rr_vec", exc_vec, 0);

`ifdef EXC_STATS_EN
        do_reset();
        cp0_handle = 1'b1;
        step();
        cp0_handle = 1'b0;
        step();
        cp0_handle = 1'b1;
        step();
        cp0_handle = 1'b0;
        step();
        if_valid = 1'b1;
        if_pc    = 32'h8000_6000;
        step();
        if_valid = 1'b0;
        id_eret  = 1'b1;
        step();
        id_eret = 1'b0;
        step();
        chk("st_eret", eret_out, 1);
        step();
        step();
        chk("st_count", exc_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
